// File: rtl/q_rotary_enc_gen.sv
// q_rotary_enc_gen: quadrature encoder emulator.
// Turns single-count step requests into rate-limited A/B quadrature edges.
// Also produces a once-per-revolution Z index pulse.
// Ports:
//   clock, sclr_n            clock and synchronous active-low reset
//   ena, step, dir           edge enable, one-count request, direction (1 = +1)
//   A, B, Z                  registered quadrature and index outputs
//   position, pending        emitted-edge count, requested-but-not-emitted count
//   busy, overflow, ovf_clr  pending != 0, sticky saturation flag and its clear
//   addr, be, write, data    byte-masked config write (0 = PERIOD, 1 = CPR)
module q_rotary_enc_gen #(
  parameter int unsigned PERIOD_DEF = 32768,
  parameter int unsigned CPR_DEF    = 4000
) (
  input  logic               clock,
  input  logic               sclr_n,
  input  logic               ena,
  input  logic               step,
  input  logic               dir,
  output logic               A,
  output logic               B,
  output logic               Z,
  output logic signed [31:0] position,
  output logic signed [15:0] pending,
  output logic               busy,
  output logic               overflow,
  input  logic               ovf_clr,
  input  logic               addr,
  input  logic [1:0]         be,
  input  logic               write,
  input  logic [15:0]        data
);

  localparam int unsigned PW = 32;
  localparam int unsigned RW = 16;
  localparam int unsigned SW = 18;

  logic [1:0]           ph, ph_n;
  logic [RW-1:0]        angle, angle_n;
  logic [RW-1:0]        timer, timer_n;
  logic [RW-1:0]        period, period_n;
  logic [RW-1:0]        cpr, cpr_n;
  logic signed [PW-1:0] pos_n;
  logic signed [RW-1:0] pend_n;
  logic                 ovf_n, busy_n, a_n, b_n, z_n;
  logic                 fire, ovf_set;
  logic signed [1:0]    e_v, s_v;
  logic signed [SW-1:0] sum;

  // Next-state logic: accumulator, edge issue, angle, timer and register writes.
  always_comb begin
    ph_n     = ph;
    angle_n  = angle;
    timer_n  = timer;
    period_n = period;
    cpr_n    = cpr;
    pos_n    = position;
    pend_n   = pending;
    ovf_set  = 1'b0;
    e_v      = 2'sb00;
    s_v      = 2'sb00;

    fire = ena && (pending != 16'sd0) && (timer == '0);
    if (fire) e_v = pending[RW-1] ? 2'sb11 : 2'sb01;
    if (step) s_v = dir ? 2'sb01 : 2'sb11;

    // A step that would push past the signed 16-bit range is dropped.
    sum = SW'(pending) - SW'(e_v) + SW'(s_v);
    if (sum > 18'sd32767 || sum < -18'sd32768) begin
      pend_n  = pending - RW'(e_v);
      ovf_set = 1'b1;
    end else begin
      pend_n  = RW'(sum);
    end

    if (fire) begin
      if (!pending[RW-1]) begin
        ph_n  = ph + 2'd1;
        pos_n = position + 32'sd1;
        if (cpr == '0)                 angle_n = '0;
        else if (angle >= cpr - 16'd1) angle_n = '0;
        else                           angle_n = angle + 16'd1;
      end else begin
        ph_n  = ph - 2'd1;
        pos_n = position - 32'sd1;
        if (cpr == '0)        angle_n = '0;
        else if (angle == '0) angle_n = cpr - 16'd1;
        else                  angle_n = angle - 16'd1;
      end
      timer_n = (period == '0) ? '0 : period - 16'd1;
    end else if (timer != '0) begin
      timer_n = timer - 16'd1;
    end

    if (write) begin
      if (!addr) begin
        if (be[0]) period_n[7:0]  = data[7:0];
        if (be[1]) period_n[15:8] = data[15:8];
      end else begin
        if (be[0]) cpr_n[7:0]  = data[7:0];
        if (be[1]) cpr_n[15:8] = data[15:8];
      end
    end

    // Set wins over a coincident clear.
    ovf_n  = ovf_set | (overflow & ~ovf_clr);
    a_n    = ph_n[0] ^ ph_n[1];
    b_n    = ph_n[1];
    z_n    = (angle_n == '0) && (cpr_n != '0);
    busy_n = (pend_n != 16'sd0);
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      ph       <= '0;
      angle    <= '0;
      timer    <= '0;
      period   <= RW'(PERIOD_DEF);
      cpr      <= RW'(CPR_DEF);
      position <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      A        <= 1'b0;
      B        <= 1'b0;
      Z        <= (CPR_DEF != 0);
    end else begin
      ph       <= ph_n;
      angle    <= angle_n;
      timer    <= timer_n;
      period   <= period_n;
      cpr      <= cpr_n;
      position <= pos_n;
      pending  <= pend_n;
      overflow <= ovf_n;
      busy     <= busy_n;
      A        <= a_n;
      B        <= b_n;
      Z        <= z_n;
    end
  end

endmodule

// File: tb/tb_q_rotary_enc_gen.sv
// Testbench for q_rotary_enc_gen: a per-cycle reference model feeds a queue.
// A negedge monitor pops the queue and compares it against the DUT outputs.
module tb_q_rotary_enc_gen;

  localparam int unsigned PERIOD_DEF = 32768;
  localparam int unsigned CPR_DEF    = 4000;

  logic               clock = 1'b0;
  logic               sclr_n = 1'b0;
  logic               ena = 1'b0, step = 1'b0, dir = 1'b0, ovf_clr = 1'b0;
  logic               addr = 1'b0, write = 1'b0;
  logic [1:0]         be = 2'b00;
  logic [15:0]        data = 16'h0;
  logic               A, B, Z, busy, overflow;
  logic signed [31:0] position;
  logic signed [15:0] pending;

  q_rotary_enc_gen #(.PERIOD_DEF(PERIOD_DEF), .CPR_DEF(CPR_DEF)) dut (
    .clock(clock), .sclr_n(sclr_n), .ena(ena), .step(step), .dir(dir),
    .A(A), .B(B), .Z(Z), .position(position), .pending(pending),
    .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr),
    .addr(addr), .be(be), .write(write), .data(data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic               a;
    logic               b;
    logic               z;
    logic signed [31:0] pos;
    logic signed [15:0] pend;
    logic               busy;
    logic               ovf;
    logic               rst;
  } snap_t;

  snap_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: counts as plain integers, A/B derived from position mod 4.
  int          m_pend, m_pos, m_angle, m_timer;
  logic [15:0] m_period, m_cpr;
  bit          m_ovf;

  always @(posedge clock) begin
    snap_t s;
    int    e, sv, t;
    bit    set;
    if (!sclr_n) begin
      m_pend = 0; m_pos = 0; m_angle = 0; m_timer = 0; m_ovf = 0;
      m_period = 16'(PERIOD_DEF); m_cpr = 16'(CPR_DEF);
    end else begin
      e = 0;
      if (ena && m_pend != 0 && m_timer == 0) e = (m_pend > 0) ? 1 : -1;
      sv = step ? (dir ? 1 : -1) : 0;
      t = m_pend - e + sv;
      set = 0;
      if (t > 32767 || t < -32768) begin
        t = m_pend - e;
        set = 1;
      end
      m_ovf = set || (m_ovf && !ovf_clr);
      m_pend = t;
      if (e != 0) begin
        m_pos = m_pos + e;
        if (m_cpr == 0)                         m_angle = 0;
        else if (e > 0)                         m_angle = (m_angle >= int'(m_cpr) - 1) ? 0 : m_angle + 1;
        else                                    m_angle = (m_angle == 0) ? int'(m_cpr) - 1 : m_angle - 1;
        m_timer = (m_period > 1) ? int'(m_period) - 1 : 0;
      end else if (m_timer > 0) begin
        m_timer = m_timer - 1;
      end
      if (write) begin
        if (!addr) begin
          if (be[0]) m_period[7:0]  = data[7:0];
          if (be[1]) m_period[15:8] = data[15:8];
        end else begin
          if (be[0]) m_cpr[7:0]  = data[7:0];
          if (be[1]) m_cpr[15:8] = data[15:8];
        end
      end
    end
    case (m_pos & 3)
      0:       begin s.a = 1'b0; s.b = 1'b0; end
      1:       begin s.a = 1'b1; s.b = 1'b0; end
      2:       begin s.a = 1'b1; s.b = 1'b1; end
      default: begin s.a = 1'b0; s.b = 1'b1; end
    endcase
    s.z    = (m_angle == 0) && (m_cpr != 0);
    s.pos  = 32'(m_pos);
    s.pend = 16'(m_pend);
    s.busy = (m_pend != 0);
    s.ovf  = m_ovf;
    s.rst  = !sclr_n;
    exp_q.push_back(s);
  end

  // Monitor: one comparison per cycle, plus a single-toggle check on A/B.
  logic pa = 1'b0, pb = 1'b0;
  always @(negedge clock) begin
    snap_t x;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty at %0t: got no expected entry, required one per cycle", $time);
    end else begin
      x = exp_q.pop_front();
      vectors++;
      if ({A, B, Z, position, pending, busy, overflow} !==
          {x.a, x.b, x.z, x.pos, x.pend, x.busy, x.ovf}) begin
        miscompares++;
        $display("FAIL outputs at %0t: got A=%b B=%b Z=%b pos=%0d pend=%0d busy=%b ovf=%b, required A=%b B=%b Z=%b pos=%0d pend=%0d busy=%b ovf=%b",
                 $time, A, B, Z, position, pending, busy, overflow,
                 x.a, x.b, x.z, x.pos, x.pend, x.busy, x.ovf);
      end
      if (!x.rst) begin
        vectors++;
        if ((A !== pa) && (B !== pb)) begin
          miscompares++;
          $display("FAIL double_toggle at %0t: got AB %b%b -> %b%b, required at most one change", $time, pa, pb, A, B);
        end
      end
    end
    pa = A;
    pb = B;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic a, input logic [1:0] b, input logic [15:0] d);
    addr = a; be = b; data = d; write = 1'b1;
    tick();
    write = 1'b0; be = 2'b00;
  endtask

  task automatic stp(input logic d);
    step = 1'b1; dir = d;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset();
    sclr_n = 1'b0;
    tick();
    sclr_n = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    sclr_n = 1'b1;

    // Three forward steps at PERIOD=4, CPR=8.
    wr(1'b0, 2'b11, 16'd4);
    wr(1'b1, 2'b11, 16'd8);
    ena = 1'b1;
    repeat (3) stp(1'b1);
    repeat (20) tick();

    // Ten forward then ten reverse steps with random gaps.
    repeat (10) begin stp(1'b1); repeat ($urandom_range(0, 6)) tick(); end
    repeat (60) tick();
    repeat (10) begin stp(1'b0); repeat ($urandom_range(0, 6)) tick(); end
    repeat (60) tick();

    // Byte-masked PERIOD writes: low byte only, then full clear.
    wr(1'b0, 2'b11, 16'h0104);
    wr(1'b0, 2'b01, 16'h0000);
    repeat (2) stp(1'b1);
    repeat (540) tick();
    wr(1'b0, 2'b11, 16'h0000);
    repeat (5) stp(1'b1);
    repeat (10) tick();

    // Saturation with edges disabled, then clear behaviour.
    ena = 1'b0;
    repeat (32768) stp(1'b1);
    step = 1'b1; dir = 1'b1; ovf_clr = 1'b1;
    tick();
    step = 1'b0;
    tick();
    ovf_clr = 1'b0;
    wr(1'b0, 2'b11, 16'd3);
    ena = 1'b1;
    repeat (100) tick();

    // Randomised traffic including config writes and CPR=0.
    do_reset();
    wr(1'b1, 2'b11, 16'd5);
    wr(1'b0, 2'b11, 16'd2);
    for (int i = 0; i < 600; i++) begin
      step    = ($urandom % 3) == 0;
      dir     = ($urandom % 3) != 0;
      ena     = ($urandom % 8) != 0;
      ovf_clr = ($urandom % 16) == 0;
      if (($urandom % 40) == 0) begin
        addr = $urandom % 2; be = 2'($urandom); data = 16'($urandom_range(0, 9)); write = 1'b1;
      end
      tick();
      write = 1'b0;
    end
    step = 1'b0; ovf_clr = 1'b0; ena = 1'b1;

    // Reset in the middle of a burst.
    wr(1'b0, 2'b11, 16'd2);
    repeat (20) stp(1'b1);
    repeat (8) tick();
    do_reset();
    repeat (20) tick();

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
